// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 datapath types, FSM encoding and column slicing helper.
package aes_pkg;
    localparam int NB = 4;
    typedef logic [127:0] state_t;
    typedef logic [31:0] word_t;
    typedef enum logic {IDLE, ACCUM} combine_st_e;
    function automatic word_t col(input state_t s, input int j);
        return s[127-32*j -: 32];
    endfunction
endpackage

// File: rtl/aes_sbox_extract.sv
// aes_sbox_extract: turns T-table words into round contributions; with AES_FINAL_ROUND_EN
// defined, final_round selects the bare S-box byte at its row position instead.
module aes_sbox_extract (
    input  logic [31:0] p0,
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    input  logic        final_round,
    output logic [31:0] c0,
    output logic [31:0] c1,
    output logic [31:0] c2,
    output logic [31:0] c3
);
`ifdef AES_FINAL_ROUND_EN
    assign c0 = final_round ? {p0[23:16], 24'h0} : p0;
    assign c1 = final_round ? {8'h0, p1[7:0], 16'h0} : p1;
    assign c2 = final_round ? {16'h0, p2[31:24], 8'h0} : p2;
    assign c3 = final_round ? {24'h0, p3[23:16]} : p3;
`else
    logic unused_final;
    assign unused_final = final_round;
    assign c0 = p0;
    assign c1 = p1;
    assign c2 = p2;
    assign c3 = p3;
`endif
endmodule

// File: rtl/aes_round_combine.sv
// aes_round_combine: ShiftRows routing plus round-key accumulation over four column beats.
// Final-round (S-box only) mode exists only when AES_FINAL_ROUND_EN is defined.
module aes_round_combine
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_first,
    input  logic [31:0]  p0,
    input  logic [31:0]  p1,
    input  logic [31:0]  p2,
    input  logic [31:0]  p3,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] out_state,
    output logic         out_valid,
    output logic         sync_err
);
    combine_st_e st;
    logic [1:0]  i;
    logic [1:0]  ie;
    logic        fr;
    word_t       acc [NB];
    word_t       c   [NB];
    word_t       add [NB];
    word_t       nxt [NB];

    aes_sbox_extract u_extract (
        .p0(p0), .p1(p1), .p2(p2), .p3(p3),
        .final_round(in_first ? final_round : fr),
        .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3])
    );

    // A beat from column ie feeds row r into output column ie-r, so column j takes row ie-j.
    assign ie = in_first ? 2'd0 : i;
    for (genvar j = 0; j < NB; j++) begin : g_route
        assign add[j] = c[ie - 2'(j)];
        assign nxt[j] = (in_first ? col(round_key, j) : acc[j]) ^ add[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            i         <= 2'd0;
            fr        <= 1'b0;
            out_state <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            for (int j = 0; j < NB; j++) acc[j] <= '0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid && (in_first || st == ACCUM)) begin
                for (int j = 0; j < NB; j++) acc[j] <= nxt[j];
                i <= ie + 2'd1;
                if (in_first) begin
                    fr       <= final_round;
                    st       <= ACCUM;
                    sync_err <= (st == ACCUM);
                end else if (i == 2'd3) begin
                    out_state <= {nxt[0], nxt[1], nxt[2], nxt[3]};
                    out_valid <= 1'b1;
                    st        <= IDLE;
                end
            end else if (in_valid) begin
                sync_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_round_combine.sv
// tb_aes_round_combine: scoreboard bench; drivers push expected results, a negedge monitor checks them.
module tb_aes_round_combine;
    logic         clk = 0, rst_n = 0, in_valid = 0, in_first = 0, final_round = 0;
    logic [31:0]  p0 = 0, p1 = 0, p2 = 0, p3 = 0;
    logic [127:0] round_key = 0, out_state;
    logic         out_valid, sync_err;

    localparam logic [127:0] R1 = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] K1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] E1 = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
    localparam logic [127:0] RF = 128'heb598b1b_402ea1c3_f2381342_1e84e7d2;
    localparam logic [127:0] KF = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] EF = 128'h3925841d_02dc09fb_dc118597_196a0b32;

    aes_round_combine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .round_key(round_key),
        .final_round(final_round), .out_state(out_state),
        .out_valid(out_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [127:0] st; int at;} exp_t;
    exp_t q[$];
    int   sq[$];
    exp_t e;
    int   se;
    int   checks = 0, fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r ^= a;
            a = xt(a);
        end
        return r;
    endfunction

    // S-box from first principles: x^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        for (int k = 0; k < 254; k++) v = gm(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] tl(input logic [31:0] w);
        logic [7:0] s0, s1, s2, s3;
        s0 = sbox(w[31:24]); s1 = sbox(w[23:16]); s2 = sbox(w[15:8]); s3 = sbox(w[7:0]);
        return {xt(s0), s0, s0, xt(s0) ^ s0,
                xt(s1) ^ s1, xt(s1), s1, s1,
                s2, xt(s2) ^ s2, xt(s2), s2,
                s3, s3, xt(s3) ^ s3, xt(s3)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0; in_first = 0;
        end
    endtask

    task automatic beat(input logic [127:0] s, input int k, input logic first,
                        input logic [127:0] key, input logic fr);
        logic [31:0] w;
        w = s[127-32*k -: 32];
        @(posedge clk); #1;
        in_valid = 1; in_first = first; round_key = key; final_round = fr;
        {p0, p1, p2, p3} = tl(w);
    endtask

    task automatic block(input logic [127:0] s, input logic [127:0] key, input logic fr,
                         input logic [127:0] ex, input int gap);
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && gap > 0) idle($urandom_range(0, gap));
            beat(s, k, k == 0, key, fr);
        end
        q.push_back('{ex, cyc + 1});
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected out_valid at cycle %0d: got 1 want 0", cyc);
            end else begin
                e = q.pop_front();
                chk("out_state", out_state, e.st);
                chk("out_valid_cycle", 128'(cyc), 128'(e.at));
            end
        end
        if (sync_err) begin
            if (sq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected sync_err at cycle %0d: got 1 want 0", cyc);
            end else begin
                se = sq.pop_front();
                chk("sync_err_cycle", 128'(cyc), 128'(se));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);
        chk("reset_out_state", out_state, 128'h0);
        chk("reset_out_valid", 128'(out_valid), 128'h0);
        chk("reset_sync_err", 128'(sync_err), 128'h0);

        block(R1, K1, 0, E1, 0);
        idle(3);
`ifdef AES_FINAL_ROUND_EN
        block(RF, KF, 1, EF, 0);
`else
        block(R1, K1, 1, E1, 0);
`endif
        idle(3);

        // Stray beat in IDLE: sync_err only.
        beat(R1, 1, 0, K1, 0);
        sq.push_back(cyc + 1);
        idle(3);

        // in_first at beat 2 restarts the block.
        beat(R1, 0, 1, K1, 0);
        beat(R1, 1, 0, K1, 0);
        beat(R1, 0, 1, K1, 0);
        sq.push_back(cyc + 1);
        for (int k = 1; k < 4; k++) beat(R1, k, 0, K1, 0);
        q.push_back('{E1, cyc + 1});
        idle(3);

        block(R1, K1, 0, E1, 0);
        block(R1, K1, 0, E1, 0);
        idle(3);

        block(R1, K1, 0, E1, 3);
        idle(2);
        block(R1, K1, 0, E1, 4);
        idle(3);

        // Reset right after beat 2 is sampled.
        beat(R1, 0, 1, K1, 0);
        beat(R1, 1, 0, K1, 0);
        beat(R1, 2, 0, K1, 0);
        @(posedge clk); #1;
        rst_n = 0; in_valid = 0; in_first = 0;
        #2;
        chk("midreset_out_state", out_state, 128'h0);
        chk("midreset_out_valid", 128'(out_valid), 128'h0);
        idle(2);
        rst_n = 1;
        idle(2);
        block(R1, K1, 0, E1, 0);
        idle(6);

        chk("pending_results", 128'(q.size()), 128'h0);
        chk("pending_sync_errs", 128'(sq.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/aes_round_combine.md
# aes_round_combine

Downstream partner of `table_lookup` in the AES-128 T-table datapath. It consumes the four per-column T-table words p0..p3, one state column per beat over four beats. It applies the ShiftRows routing, XORs the contributions into four column accumulators seeded with the round key, and emits the 128-bit next-round state. It also supports a final-round mode that takes only the plain S-box byte, with no MixColumns.

## Interface
No parameters; widths are fixed by AES-128.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- in_valid  in  1  A beat is present on p0..p3 this cycle.
- in_first  in  1  Qualifies beat 0 (state column 0) of a block.
- p0, p1, p2, p3  in  32 each  Registered `table_lookup` outputs for the current column. p_r = T_r[row-r byte]; p0 = {2s,s,s,3s}, p1 = {3s,2s,s,s}, p2 = {s,3s,2s,s}, p3 = {s,s,3s,2s}.
- round_key  in  128  Round key; sampled only on the beat-0 cycle. Column j is bits [127-32j -: 32].
- final_round  in  1  Sampled on beat 0. When 1, the block runs in S-box-only mode (see Configuration).
- out_state  out  128  Next state; column j is bits [127-32j -: 32]. Holds its value until the next result.
- out_valid  out  1  One-cycle pulse when out_state is updated.
- sync_err  out  1  One-cycle pulse on a framing violation.

## Operation
- States:
  - IDLE: waiting for beat 0.
  - ACCUM: beats 1..3 expected; a 2-bit beat index i tracks progress.
- IDLE, in_valid & in_first: this is beat 0.
  - acc[j] <= key column j, XOR the contributions of column 0.
  - Latch final_round; i <= 1; go to ACCUM.
- IDLE, in_valid & !in_first: drop the beat and pulse sync_err.
- ACCUM, in_valid & !in_first: add the contributions of column i; i <= i+1.
  - On i==3: write out_state <= acc ^ contributions and go to IDLE.
- ACCUM, in_valid & in_first: discard the partial block and pulse sync_err. Treat the beat as a fresh beat 0 (reload the key, i <= 1).
- ACCUM, !in_valid: hold. Gaps between beats are allowed without limit.
- Contribution routing, mix mode: beat from input column i adds p_r to acc[(i - r) mod 4] for r = 0..3.
- Contribution routing, final mode (same routing): replace p_r with a word that is zero except for the S-box byte s, placed at row r's position [31-8r -: 8]. The source bytes are:
  - p0[23:16]
  - p1[7:0]
  - p2[31:24]
  - p3[23:16]
- All arithmetic is 32-bit XOR in GF(2^8); there is no carry or width growth.

## Timing
- Reset values: out_state = 0, out_valid = 0, sync_err = 0, state IDLE, i = 0, all acc = 0.
- Latency: out_valid rises the cycle after the beat-3 edge, i.e. 1 cycle after the last beat is sampled.
- Back-to-back blocks:
  - Beat 0 of the next block may arrive in the cycle immediately after beat 3, giving full throughput of one block per 4 beats.
  - out_valid of block N and beat 0 of block N+1 may coincide; they are independent.
- rst_n asserted mid-block: everything returns to reset values immediately. A pending out_valid is not emitted, and the partial block is lost.
- sync_err and out_valid never assert in the same cycle for the same beat.

## Configuration
- `AES_FINAL_ROUND_EN` defined:
  - final_round is honoured and the S-box byte extraction path is built.
- `AES_FINAL_ROUND_EN` undefined:
  - The final_round port still exists but is ignored; every block uses mix mode.
  - The byte-extraction muxes are not synthesised.

## Structure
- A shared package `aes_pkg` holds:
  - `state_t` (128-bit)
  - `word_t` (32-bit)
  - enum `combine_st_e` {IDLE, ACCUM}
  - function `col(state, j)` for column slicing
  - constant `NB = 4`
- One sub-module, `aes_sbox_extract`: a combinational function of p0..p3 and final_round that produces the four contribution words. The top level owns the FSM, the beat index and the accumulators.

## Test plan
- Reset: hold rst_n low, then release. Required: out_state = 0, out_valid = 0, sync_err = 0.
- FIPS-197 App. B round 1, mix mode. Feed four beats through a `table_lookup` model:
  - State columns: 193de3be, a0f4e22b, 9ac68d2a, e9f84808
  - round_key = a0fafe1788542cb123a339392a6c7605
  - Required: out_state = a49c7ff2689f352b6b5bea43026a5049, out_valid pulsed once, 1 cycle after the last beat.
- Final round (macro defined), final_round = 1:
  - State columns: eb598b1b, 402ea1c3, f2381342, 1e84e7d2
  - round_key = d014f9a8c9ee2589e13f0cc8b6630ca6
  - Required: out_state = 3925841d02dc09fbdc11859719 6a0b32 with the space removed, i.e. 3925841d02dc09fbdc118597196a0b32.
- Framing errors:
  - A beat without in_first in IDLE: sync_err pulses and out_valid never asserts.
  - in_first at beat 2: sync_err pulses, the block restarts, and after 3 more beats out_state matches a clean run.
- Back-to-back and gaps:
  - Two round-1 blocks with no idle cycle between them: two out_valid pulses 4 cycles apart.
  - Random in_valid gaps between beats: results are unchanged.
- Reset during beat 2: no out_valid. The next clean block produces correct results.
